// File: rtl/key_hex_pkg.sv
// ---------------------------------------------------------------------------
// key_hex_pkg
// Shared types and constants for the key_hex_counter front end: repeat FSM
// state encoding, key index assignments, the two step sizes and the
// modulo-2^16 step helper.
// ---------------------------------------------------------------------------
package key_hex_pkg;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

   localparam int KEY_INC  = 0;
   localparam int KEY_DEC  = 1;
   localparam int KEY_CLR  = 2;
   localparam int KEY_STEP = 3;

   localparam logic [15:0] STEP_SMALL = 16'h0001;
   localparam logic [15:0] STEP_LARGE = 16'h0010;

   // Next counter value; the 16-bit result wraps naturally in both directions.
   function automatic logic [15:0] step_value(input logic [15:0] cur,
                                              input logic        up,
                                              input logic        big);
      logic [15:0] step;
      step = big ? STEP_LARGE : STEP_SMALL;
      return up ? (cur + step) : (cur - step);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One push-button: two-flop synchroniser followed by a stability counter.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   key_n    in   raw button, active-low, asynchronous
//   level    out  debounced level, active-high (1 = pressed)
//   press    out  one-cycle pulse when level goes 0->1
// ---------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level_d;
   logic [CNT_W-1:0] cnt;
   logic             sample_down;

   assign sample_down = ~sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= key_n;
         sync2   <= sync1;
         level_d <= level;
         // Any sample agreeing with the accepted level restarts the count,
         // so only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips it.
         if (sample_down == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sample_down;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/key_hex_counter.sv
// ---------------------------------------------------------------------------
// key_hex_counter
// Four debounced push-buttons drive a 16-bit up/down counter with
// hold-to-auto-repeat, clear and a x1/x16 step toggle.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   key_n[3:0] in   raw buttons, active-low: [0] inc, [1] dec, [2] clear, [3] step toggle
//   hex0..hex3 out  value nibbles, hex0 = value[3:0] ... hex3 = value[15:12]
//   step16     out  1 = step 0x0010, 0 = step 0x0001
//   pressed    out  debounced key levels, active-high
// ---------------------------------------------------------------------------
module key_hex_counter
   import key_hex_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] key_n,
   output logic [3:0] hex0,
   output logic [3:0] hex1,
   output logic [3:0] hex2,
   output logic [3:0] hex3,
   output logic       step16,
   output logic [3:0] pressed
);

   // rc is shared by DELAY and REPEAT, so it is sized for the longer interval.
   localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;
   localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

   logic [3:0]      press_edge;
   logic            dir_active;
   logic            dir_prev;
   logic            dir_rise;
   rpt_state_t      state;
   logic [RC_W-1:0] rc;
   logic [15:0]     value;

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset_n(reset_n),
         .key_n  (key_n[i]),
         .level  (pressed[i]),
         .press  (press_edge[i])
      );
   end

   // Both inc and dec held counts as no key, so a direct direction change
   // always passes through an inactive cycle and restarts the sequence.
   assign dir_active = pressed[KEY_INC] ^ pressed[KEY_DEC];
   // A rising edge (not a held level) is required to start counting, so a
   // key still held when clear is released does not resume counting.
   assign dir_rise   = dir_active & ~dir_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir_prev <= 1'b0;
         step16   <= 1'b0;
         state    <= IDLE;
         rc       <= '0;
         value    <= '0;
      end else begin
         dir_prev <= dir_active;
         // A step applied on the same edge still sees the old step16.
         if (press_edge[KEY_STEP]) begin
            step16 <= ~step16;
         end

         if (pressed[KEY_CLR]) begin
            value <= '0;
            state <= IDLE;
            rc    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (dir_rise) begin
                     value <= step_value(value, pressed[KEY_INC], step16);
                     rc    <= '0;
                     state <= DELAY;
                  end
               end
               DELAY: begin
                  if (!dir_active) begin
                     rc    <= '0;
                     state <= IDLE;
                  end else if (rc == DELAY_LAST) begin
                     value <= step_value(value, pressed[KEY_INC], step16);
                     rc    <= '0;
                     state <= REPEAT;
                  end else begin
                     rc <= rc + 1'b1;
                  end
               end
               REPEAT: begin
                  if (!dir_active) begin
                     rc    <= '0;
                     state <= IDLE;
                  end else if (rc == PERIOD_LAST) begin
                     value <= step_value(value, pressed[KEY_INC], step16);
                     rc    <= '0;
                  end else begin
                     rc <= rc + 1'b1;
                  end
               end
               default: begin
                  rc    <= '0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign hex0 = value[3:0];
   assign hex1 = value[7:4];
   assign hex2 = value[11:8];
   assign hex3 = value[15:12];

endmodule
